// File: rtl/uart_hex_fmt_if.sv
// Sequencer-to-UART hex formatter bus: result word in, ASCII byte stream out.
interface uart_hex_fmt_if #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
);
   logic [DW-1:0]          i_data;
   logic                   i_valid;
   logic                   i_tx_busy;
   logic [7:0]             o_tx_data;
   logic                   o_tx_stb;
   logic [$clog2(DEPTH):0] o_level;
   logic                   o_ovf;
   logic                   o_idle;

   modport master (
      output i_data, i_valid, i_tx_busy,
      input  o_tx_data, o_tx_stb, o_level, o_ovf, o_idle
   );

   modport slave (
      input  i_data, i_valid, i_tx_busy,
      output o_tx_data, o_tx_stb, o_level, o_ovf, o_idle
   );
endinterface

// File: rtl/uart_hex_fmt.sv
// Buffers result words in a small FIFO and streams each one to the UART as
// uppercase ASCII hex (MSB nibble first), optionally followed by CR LF.
module uart_hex_fmt #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int EOL   = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_hex_fmt_if.slave bus
);
   localparam int NCHAR = DW / 4;
   localparam int NTOT  = NCHAR + 2 * EOL;
   localparam int AW    = $clog2(DEPTH);
   localparam int LW    = AW + 1;
   localparam int CW    = $clog2(NTOT + 1);
   localparam logic [CW-1:0] LAST_CHAR = CW'(NTOT - 1);
   localparam logic [CW-1:0] CR_CHAR   = CW'(NCHAR);

   typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_t;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] count_q, count_d;
   state_t        state_q, state_d;
   logic [DW-1:0] sh_q, sh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          stb_q, stb_d;
   logic          ovf_q, ovf_d;
   logic          idle_q, idle_d;
   logic          full, empty, pop, push;
   logic [7:0]    cur_char;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   // FIFO bookkeeping, character selection and the byte-pacing FSM
   always_comb begin
      full      = (count_q == LW'(DEPTH));
      empty     = (count_q == '0);
      pop       = (state_q == IDLE) && !empty;
      // a pop in the same cycle frees the slot, so a push while full is kept
      push      = bus.i_valid && (!full || pop);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      state_d   = state_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      stb_d     = 1'b0;
      tx_data_d = tx_data_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (bus.i_valid && !push) ovf_d = 1'b1;

      // sh is shifted left after each digit, so the current nibble is always on top
      if (cnt_q < CR_CHAR)       cur_char = hex_ascii(sh_q[DW-1 -: 4]);
      else if (cnt_q == CR_CHAR) cur_char = 8'h0D;
      else                       cur_char = 8'h0A;

      unique case (state_q)
         IDLE: if (pop) begin
            sh_d    = mem_q[rd_ptr_q];
            cnt_d   = '0;
            state_d = SEND;
         end
         SEND: if (!bus.i_tx_busy) begin
            stb_d     = 1'b1;
            tx_data_d = cur_char;
            state_d   = HOLD;
         end
         // UART raises busy a cycle after the strobe; don't trust it here
         HOLD: state_d = WAIT;
         WAIT: if (!bus.i_tx_busy) begin
            if (cnt_q == LAST_CHAR) begin
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               sh_d    = sh_q << 4;
               state_d = SEND;
            end
         end
         default: state_d = IDLE;
      endcase

      idle_d = (count_d == '0) && (state_d == IDLE);
   end

   // FIFO storage; contents need no reset since pointers gate every read
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.i_data;
   end

   // state and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= IDLE;
         sh_q      <= '0;
         cnt_q     <= '0;
         tx_data_q <= '0;
         stb_q     <= 1'b0;
         ovf_q     <= 1'b0;
         idle_q    <= 1'b1;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         sh_q      <= sh_d;
         cnt_q     <= cnt_d;
         tx_data_q <= tx_data_d;
         stb_q     <= stb_d;
         ovf_q     <= ovf_d;
         idle_q    <= idle_d;
      end
   end

   assign bus.o_tx_data = tx_data_q;
   assign bus.o_tx_stb  = stb_q;
   assign bus.o_level   = count_q;
   assign bus.o_ovf     = ovf_q;
   assign bus.o_idle    = idle_q;
endmodule

// File: tb/tb_uart_hex_fmt.sv
// Bench for uart_hex_fmt: an 8-bit/CRLF instance and a 16-bit/no-EOL instance,
// each with a busy-counter UART model and a byte scoreboard.
module tb_uart_hex_fmt;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_hex_fmt_if #(.DW(8),  .DEPTH(4)) ba ();
   uart_hex_fmt_if #(.DW(16), .DEPTH(4)) bb ();

   uart_hex_fmt #(.DW(8),  .DEPTH(4), .EOL(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
   uart_hex_fmt #(.DW(16), .DEPTH(4), .EOL(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

   typedef struct {
      logic [7:0] d;
      logic [7:0] c1;
      logic [7:0] c0;
   } vec_t;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int na_stb = 0;
   int nb_stb = 0;
   int max_lvl = 0;
   int bcnt_a = 0;
   int bcnt_b = 0;
   logic force_busy = 1'b0;
   logic model_en = 1'b1;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   vec_t tbl[4];
   string hs = "0123456789ABCDEF";

   always @(posedge clk) cyc <= cyc + 1;

   // UART models: busy for a fixed time after each strobe
   always @(posedge clk) begin
      if (!rst_n) bcnt_a <= 0;
      else if (model_en && ba.o_tx_stb) bcnt_a <= 10;
      else if (bcnt_a != 0) bcnt_a <= bcnt_a - 1;
      if (!rst_n) bcnt_b <= 0;
      else if (bb.o_tx_stb) bcnt_b <= 5;
      else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
   end
   assign ba.i_tx_busy = force_busy | (bcnt_a != 0);
   assign bb.i_tx_busy = (bcnt_b != 0);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // scoreboard monitor: every strobe must match the next expected byte
   always @(negedge clk) begin
      if (ba.o_tx_stb) begin
         na_stb++;
         if (qa.size() == 0) check("a_unexpected_byte", {24'h0, ba.o_tx_data}, 32'hFFFF_FFFF);
         else check("a_byte", {24'h0, ba.o_tx_data}, {24'h0, qa.pop_front()});
      end
      if (bb.o_tx_stb) begin
         nb_stb++;
         if (qb.size() == 0) check("b_unexpected_byte", {24'h0, bb.o_tx_data}, 32'hFFFF_FFFF);
         else check("b_byte", {24'h0, bb.o_tx_data}, {24'h0, qb.pop_front()});
      end
      if (int'(ba.o_level) > max_lvl) max_lvl = int'(ba.o_level);
   end

   task automatic exp_a(input logic [7:0] d);
      qa.push_back(hs[int'(d[7:4])]);
      qa.push_back(hs[int'(d[3:0])]);
      qa.push_back(8'h0D);
      qa.push_back(8'h0A);
   endtask

   task automatic drive_a(input logic [7:0] d);
      @(negedge clk);
      ba.i_data  = d;
      ba.i_valid = 1'b1;
   endtask

   task automatic release_a();
      @(negedge clk);
      ba.i_valid = 1'b0;
   endtask

   task automatic wait_idle_a(input string nm);
      int t = 0;
      while (!(ba.o_idle && qa.size() == 0 && bcnt_a == 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check({nm, "_drain_timeout"}, (t < 3000) ? 32'd1 : 32'd0, 32'd1);
      check({nm, "_left_in_queue"}, qa.size(), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int push_cyc;
      int t;
      int n;
      int base;
      ba.i_data = '0; ba.i_valid = 1'b0;
      bb.i_data = '0; bb.i_valid = 1'b0;
      tbl[0] = '{8'hA5, 8'h41, 8'h35};
      tbl[1] = '{8'h00, 8'h30, 8'h30};
      tbl[2] = '{8'hFF, 8'h46, 8'h46};
      tbl[3] = '{8'h9C, 8'h39, 8'h43};

      // reset state
      do_reset();
      check("rst_stb",   ba.o_tx_stb,  0);
      check("rst_data",  ba.o_tx_data, 0);
      check("rst_level", ba.o_level,   0);
      check("rst_ovf",   ba.o_ovf,     0);
      check("rst_idle",  ba.o_idle,    1);
      check("rst_idle_b", bb.o_idle,   1);

      // single word, latency to first strobe
      qa.push_back(tbl[0].c1); qa.push_back(tbl[0].c0);
      qa.push_back(8'h0D);     qa.push_back(8'h0A);
      drive_a(tbl[0].d);
      release_a();
      push_cyc = cyc;
      t = 0;
      while (!ba.o_tx_stb && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("t1_first_stb_latency", cyc - push_cyc, 2);
      wait_idle_a("t1");

      // back-to-back burst from the table
      max_lvl = 0;
      for (int i = 1; i < 4; i++) begin
         qa.push_back(tbl[i].c1); qa.push_back(tbl[i].c0);
         qa.push_back(8'h0D);     qa.push_back(8'h0A);
         drive_a(tbl[i].d);
      end
      release_a();
      wait_idle_a("t2");
      check("t2_level_peak", max_lvl, 2);
      check("t2_ovf", ba.o_ovf, 0);

      // overflow with UART stuck busy: sh + 4 kept, one dropped
      force_busy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) exp_a(8'h10 + 8'(i));
         drive_a(8'h10 + 8'(i));
      end
      release_a();
      check("t3_level_full", ba.o_level, 4);
      check("t3_ovf_set", ba.o_ovf, 1);
      check("t3_not_idle", ba.o_idle, 0);
      force_busy = 1'b0;
      wait_idle_a("t3");
      check("t3_ovf_sticky", ba.o_ovf, 1);
      check("t3_level_empty", ba.o_level, 0);

      // full FIFO, push lands on the cycle IDLE pops
      do_reset();
      model_en = 1'b0;
      force_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_a(8'hB0 + 8'(i));
         drive_a(8'hB0 + 8'(i));
      end
      release_a();
      force_busy = 1'b0;
      n = 0; t = 0;
      while (n < 4 && t < 100) begin
         @(negedge clk);
         t++;
         if (ba.o_tx_stb) n++;
      end
      check("t4_four_chars_timeout", n, 4);
      @(negedge clk);
      @(negedge clk);
      check("t4_full_before", ba.o_level, 4);
      exp_a(8'hB5);
      ba.i_data = 8'hB5;
      ba.i_valid = 1'b1;
      @(negedge clk);
      ba.i_valid = 1'b0;
      check("t4_level_after", ba.o_level, 4);
      check("t4_ovf_clear", ba.o_ovf, 0);
      wait_idle_a("t4");
      model_en = 1'b1;

      // reset during the second character aborts the word
      exp_a(8'h3C);
      drive_a(8'h3C);
      release_a();
      n = 0; t = 0;
      while (n < 2 && t < 200) begin
         @(negedge clk);
         t++;
         if (ba.o_tx_stb) n++;
      end
      check("t5_second_char_timeout", n, 2);
      #1;
      rst_n = 1'b0;
      qa.delete();
      @(negedge clk);
      check("t5_rst_stb",   ba.o_tx_stb,  0);
      check("t5_rst_data",  ba.o_tx_data, 0);
      check("t5_rst_level", ba.o_level,   0);
      check("t5_rst_ovf",   ba.o_ovf,     0);
      check("t5_rst_idle",  ba.o_idle,    1);
      rst_n = 1'b1;
      base = na_stb;
      repeat (60) @(negedge clk);
      check("t5_no_more_stb", na_stb - base, 0);

      // 16-bit word, no line ending
      qb.push_back(8'h31); qb.push_back(8'h32);
      qb.push_back(8'h33); qb.push_back(8'h34);
      base = nb_stb;
      @(negedge clk);
      bb.i_data = 16'h1234;
      bb.i_valid = 1'b1;
      @(negedge clk);
      bb.i_valid = 1'b0;
      t = 0;
      while (!(bb.o_idle && qb.size() == 0 && bcnt_b == 0) && t < 500) begin
         @(negedge clk);
         t++;
      end
      repeat (10) @(negedge clk);
      check("t6_byte_count", nb_stb - base, 4);
      check("t6_left_in_queue", qb.size(), 0);
      check("t6_idle", bb.o_idle, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
